// File: rtl/mem_stage_pkg.sv
// Shared encodings and the captured-operation bundle for the memory stage.
// Also hosts the alignment rule used when deciding whether to issue a request.
package mem_stage_pkg;

    localparam int P_XLEN = 32;
    localparam int P_RD_W = 5;

    typedef enum logic [1:0] {
        CC_NONE  = 2'b00,
        CC_LOAD  = 2'b01,
        CC_STORE = 2'b10
    } cc_e;

    typedef enum logic [1:0] {
        T_BYTE = 2'b00,
        T_HALF = 2'b01,
        T_WORD = 2'b10
    } acc_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

    typedef struct packed {
        logic [P_XLEN-1:0] addr;
        logic [1:0]        typ;
        logic              uns;
        logic              we;
        logic [P_RD_W-1:0] rd;
        logic [P_XLEN-1:0] sdata;
    } mem_op_t;

    // Type code 2'b11 is a word access as well, so only bit 1 is tested.
    function automatic logic is_misaligned(
        input logic [1:0] typ,
        input logic [1:0] a
    );
        logic w_bad;
        w_bad = 1'b0;
        if (typ[1]) begin
            w_bad = (a != 2'b00);
        end else if (typ == T_HALF) begin
            w_bad = a[0];
        end
        return w_bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a load word and extends it.
// Purely combinational.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = P_XLEN
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr,
    input  logic [1:0]      i_type,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_addr)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = '0;
        unique case (1'b1)
            i_type[1]: begin
                o_data = i_rdata;
            end
            (i_type == T_HALF): begin
                o_data = i_unsigned ? {16'h0000, w_half}
                                    : {{16{w_half[15]}}, w_half};
            end
            (i_type == T_BYTE): begin
                o_data = i_unsigned ? {24'h000000, w_byte}
                                    : {{24{w_byte[7]}}, w_byte};
            end
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues load/store requests to the data cache,
// stalls upstream while a transaction is in flight and produces writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = P_XLEN,
    parameter int RD_W = P_RD_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_ex_wb_data,
    input  logic [XLEN-1:0] i_ex_data_address,
    input  logic [1:0]      i_ex_cache_control,
    input  logic [1:0]      i_ex_type,
    input  logic            i_ex_ld_unsigned,
    input  logic [XLEN-1:0] i_ex_store_data,
    input  logic [RD_W-1:0] i_ex_rd,
    input  logic            i_ex_reg_write,
    input  logic            i_dc_ready,
    input  logic            i_dc_rvalid,
    input  logic [XLEN-1:0] i_dc_rdata,
    output logic            o_dc_req,
    output logic            o_dc_we,
    output logic [XLEN-1:0] o_dc_addr,
    output logic [3:0]      o_dc_wstrb,
    output logic [XLEN-1:0] o_dc_wdata,
    output logic [XLEN-1:0] o_wb_data,
    output logic [RD_W-1:0] o_wb_rd,
    output logic            o_wb_en,
    output logic            o_mem_stall,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_misaligned_addr
);

    state_e          r_state;
    state_e          w_next;
    mem_op_t         r_op;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_misal;
    logic            w_issue;
    logic            w_in_req;
    logic            w_in_wait;
    logic [3:0]      w_strb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_data;

    logic [XLEN-1:0] r_wb_data;
    logic [RD_W-1:0] r_wb_rd;
    logic            r_wb_en;
    logic            r_misal;
    logic [XLEN-1:0] r_misal_addr;

    assign w_is_load  = (i_ex_cache_control == CC_LOAD);
    assign w_is_store = (i_ex_cache_control == CC_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_misal    = is_misaligned(i_ex_type, i_ex_data_address[1:0]);
    assign w_issue    = (r_state == S_IDLE) & w_is_mem & ~w_misal;
    assign w_in_req   = (r_state == S_REQ);
    assign w_in_wait  = (r_state == S_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_dc_ready) begin
                    w_next = r_op.we ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_dc_rvalid) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The op bundle is only written from IDLE, so it is stable for REQ/WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op <= '0;
        end else if (w_issue) begin
            r_op.addr  <= i_ex_data_address;
            r_op.typ   <= i_ex_type;
            r_op.uns   <= i_ex_ld_unsigned;
            r_op.we    <= w_is_store;
            r_op.rd    <= i_ex_rd;
            r_op.sdata <= i_ex_store_data;
        end
    end

    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = '0;
        unique case (1'b1)
            r_op.typ[1]: begin
                w_strb  = 4'b1111;
                w_wdata = r_op.sdata;
            end
            (r_op.typ == T_HALF): begin
                w_strb  = 4'b0011 << {r_op.addr[1], 1'b0};
                w_wdata = {2{r_op.sdata[15:0]}};
            end
            (r_op.typ == T_BYTE): begin
                w_strb  = 4'b0001 << r_op.addr[1:0];
                w_wdata = {4{r_op.sdata[7:0]}};
            end
            default: begin
                w_strb  = 4'b0000;
                w_wdata = '0;
            end
        endcase
    end

    mem_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .i_rdata   (i_dc_rdata),
        .i_addr    (r_op.addr[1:0]),
        .i_type    (r_op.typ),
        .i_unsigned(r_op.uns),
        .o_data    (w_ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_en      <= 1'b0;
            r_misal      <= 1'b0;
            r_misal_addr <= '0;
        end else begin
            r_wb_en <= 1'b0;
            r_misal <= 1'b0;
            if (r_state == S_IDLE) begin
                if (!w_is_mem) begin
                    r_wb_data <= i_ex_wb_data;
                    r_wb_rd   <= i_ex_rd;
                    r_wb_en   <= i_ex_reg_write & (i_ex_rd != '0);
                end else if (w_misal) begin
                    r_misal      <= 1'b1;
                    r_misal_addr <= i_ex_data_address;
                end
            end else if (w_in_wait && i_dc_rvalid) begin
                r_wb_data <= w_ld_data;
                r_wb_rd   <= r_op.rd;
                r_wb_en   <= (r_op.rd != '0);
            end
        end
    end

    assign o_dc_req          = w_in_req;
    assign o_dc_we           = w_in_req & r_op.we;
    assign o_dc_addr         = {r_op.addr[XLEN-1:2], 2'b00};
    assign o_dc_wstrb        = w_in_req ? w_strb : 4'b0000;
    assign o_dc_wdata        = w_in_req ? w_wdata : '0;
    assign o_wb_data         = r_wb_data;
    assign o_wb_rd           = r_wb_rd;
    assign o_wb_en           = r_wb_en;
    assign o_mem_stall       = w_in_req | w_in_wait;
    assign o_misaligned      = r_misal;
    assign o_misaligned_addr = r_misal_addr;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's ALU result, data address, cache control and access type.
- Runs load/store transactions against the data cache over a req/ready + rvalid handshake.
- Produces aligned, extended writeback data for the register file, and stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width (only 32 supported).
- RD_W, 5, destination register index width.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- EX_WB_DATA  in  XLEN  ALU result from execute (already flush-masked).
- EX_DATA_ADDRESS  in  XLEN  effective load/store address.
- EX_CACHE_CONTROL  in  2  00 none, 01 load, 10 store, 11 treated as none.
- EX_TYPE  in  2  00 byte, 01 half, 1x word.
- EX_LD_UNSIGNED  in  1  1 = zero-extend load (LBU/LHU).
- EX_STORE_DATA  in  XLEN  rs2 value for stores.
- EX_RD  in  RD_W  destination register.
- EX_REG_WRITE  in  1  instruction writes rd.
- DC_READY  in  1  cache accepts request this cycle.
- DC_RVALID  in  1  load data valid.
- DC_RDATA  in  XLEN  load word, naturally aligned.
- DC_REQ  out  1  request valid.
- DC_WE  out  1  1 = store.
- DC_ADDR  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- DC_WSTRB  out  4  byte enables.
- DC_WDATA  out  XLEN  lane-replicated store data.
- WB_DATA  out  XLEN  writeback value.
- WB_RD  out  RD_W  writeback register.
- WB_EN  out  1  one-cycle write strobe.
- MEM_STALL  out  1  hold execute and upstream stages.
- MISALIGNED  out  1  one-cycle misaligned-access pulse.
- MISALIGNED_ADDR  out  XLEN  offending address, valid with MISALIGNED.

Behaviour:
- Reset: all outputs 0, state IDLE, op registers cleared.
- The reset term applies at any time. Mid-transaction reset drops DC_REQ next cycle; the data cache shares RST.
- States: IDLE, REQ, WAIT.
- MEM_STALL = (state==REQ) | (state==WAIT). It is a registered-state decode, not combinational from EX inputs.
- IDLE, non-memory op: register EX_WB_DATA → WB_DATA and EX_RD → WB_RD. WB_EN = EX_REG_WRITE & (EX_RD!=0). Latency 1 cycle.
- IDLE, memory op, misaligned (half with addr[0]=1, or word with addr[1:0]!=0):
  - No cache request.
  - Next cycle: MISALIGNED=1, MISALIGNED_ADDR=address, WB_EN=0.
  - Remain IDLE.
- IDLE, memory op, aligned:
  - Latch address, type, unsigned flag, rd, store data.
  - Next cycle: state REQ, DC_REQ=1, WB_EN=0.
- REQ: DC_REQ, DC_WE, DC_ADDR, DC_WSTRB and DC_WDATA are held stable until DC_READY.
  - On DC_READY, store: next cycle IDLE, DC_REQ=0, no writeback.
  - On DC_READY, load: next cycle WAIT, DC_REQ=0.
- WAIT: on DC_RVALID, next cycle IDLE with WB_DATA = extracted value, WB_RD = latched rd, WB_EN = (rd!=0).
- Response timing: the cache returns DC_RVALID no earlier than the cycle after acceptance. DC_RVALID outside WAIT is ignored.
- Store lanes:
  - Byte: WSTRB = 4'b0001 << addr[1:0], WDATA = {4{data[7:0]}}.
  - Half: WSTRB = 4'b0011 << {addr[1],1'b0}, WDATA = {2{data[15:0]}}.
  - Word: WSTRB = 4'b1111, WDATA = data.
- Load extraction:
  - Byte: the byte at lane addr[1:0].
  - Half: the halfword at lane addr[1].
  - Byte/half results are sign-extended unless unsigned; word is passed through.
- Pipeline handoff: while MEM_STALL=1, EX inputs are not sampled. Execute holds its outputs and has already masked control to 00 on flush.
- Flush during REQ/WAIT: an accepted or pending transaction always completes. Upstream flush only affects ops not yet captured.
- WB_EN is 0 in every cycle except completion cycles. MISALIGNED and WB_EN are never high together.

Decomposition:
- Shared package (alongside the pipeline parameter header):
  - Cache-control encodings: CC_NONE, CC_LOAD, CC_STORE.
  - Access-type encodings: T_BYTE, T_HALF, T_WORD.
  - State encodings: S_IDLE, S_REQ, S_WAIT.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], type, unsigned; output extended value. It is reused by the verification model.
- Store-lane generation stays inline.

Test Plan:
- ALU op, EX_WB_DATA=0x1234_5678, EX_RD=5, EX_REG_WRITE=1 → next cycle WB_DATA=0x12345678, WB_RD=5, WB_EN=1; MEM_STALL stays 0.
- LB with addr 0x1003, DC_RDATA=0x80AA_BBCC, DC_READY delayed 2 cycles, RVALID 1 cycle after accept:
  - DC_ADDR=0x1000 held stable through REQ; MEM_STALL high throughout.
  - Completion: WB_DATA=0xFFFF_FF80, WB_EN=1.
  - Repeat as LBU → 0x0000_0080.
- SH with addr 0x2002, data 0x0000_BEEF → DC_WSTRB=4'b1100, DC_WDATA=0xBEEF_BEEF, DC_WE=1; no WB_EN; IDLE one cycle after DC_READY.
- LW with addr 0x3001 → no DC_REQ; MISALIGNED=1 with MISALIGNED_ADDR=0x3001 for exactly one cycle; WB_EN=0.
- Corner cases:
  - RST asserted in WAIT → next cycle all outputs 0, state IDLE, later DC_RVALID ignored.
  - Load to rd=0 → WB_EN=0 at completion.
